// File: rtl/matrix_pkg.sv
// matrix_pkg: shared sizes, FSM state type and packed-entry offset helper
package matrix_pkg;
  localparam int N = 4;
  localparam int EW = 6;
  localparam int OW = 2 * EW + $clog2(N);
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  function automatic int entry_lsb(input int r, input int c, input int w);
    return ((N * N - 1) - (r * N + c)) * w;
  endfunction
endpackage

// File: rtl/matrix_mac_unit.sv
// matrix_mac_unit: combinational EW x EW multiply plus OW-bit accumulate
module matrix_mac_unit
  import matrix_pkg::*;
(
  input  logic [OW-1:0] acc_in,
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  output logic [OW-1:0] acc_out
);
  logic [2*EW-1:0] prod;
  assign prod = a * b;
  assign acc_out = acc_in + OW'(prod);
endmodule

// File: rtl/matrix_mult_engine.sv
// matrix_mult_engine: sequential N x N unsigned matrix multiply, one MAC per cycle
module matrix_mult_engine
  import matrix_pkg::*;
(
  input  logic                clock,
  input  logic                rst,
  input  logic                start,
  input  logic [N*N*EW-1:0]   mat_a,
  input  logic [N*N*EW-1:0]   mat_b,
  output logic                busy,
  output logic                done,
  output logic [N*N*OW-1:0]   mat_c
);
  localparam int CW = $clog2(N);
  state_t state, state_next;
  logic [CW-1:0] i, j, k;
  logic [OW-1:0] acc, acc_next;
  logic [N*N*EW-1:0] op_a, op_b;
  logic [N*N*OW-1:0] work, work_next;
  logic [EW-1:0] a_sel, b_sel;
  logic last_k, last;
  matrix_mac_unit u_mac (
    .acc_in (acc),
    .a      (a_sel),
    .b      (b_sel),
    .acc_out(acc_next)
  );
  always_comb begin
    a_sel = op_a[entry_lsb(int'(i), int'(k), EW) +: EW];
    b_sel = op_b[entry_lsb(int'(k), int'(j), EW) +: EW];
    last_k = k == CW'(N - 1);
    last = last_k && j == CW'(N - 1) && i == CW'(N - 1);
    work_next = work;
    work_next[entry_lsb(int'(i), int'(j), OW) +: OW] = acc_next;
    state_next = state == IDLE ? (start ? MAC : IDLE) :
                 state == MAC  ? (last ? DONE : MAC) : IDLE;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      k <= '0;
      acc <= '0;
      op_a <= '0;
      op_b <= '0;
      work <= '0;
      mat_c <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        op_a <= mat_a;
        op_b <= mat_b;
        i <= '0;
        j <= '0;
        k <= '0;
        acc <= '0;
      end
      if (state == MAC) begin
        if (last_k) begin
          work <= work_next;
          acc <= '0;
          k <= '0;
          j <= j == CW'(N - 1) ? '0 : j + 1'b1;
          if (j == CW'(N - 1)) i <= i == CW'(N - 1) ? '0 : i + 1'b1;
        end else begin
          k <= k + 1'b1;
          acc <= acc_next;
        end
        if (last) mat_c <= work_next;
      end
    end
  end
endmodule

// File: tb/tb_matrix_mult_engine.sv
// tb_matrix_mult_engine: vector table, random model checks and multi-cycle corner sequences
module tb_matrix_mult_engine;
  import matrix_pkg::*;
  localparam int NV = 8;
  localparam int NC = N * N * N;
  typedef struct {
    string name;
    logic [N*N*EW-1:0] a;
    logic [N*N*EW-1:0] b;
    logic [N*N*OW-1:0] c;
  } vec_t;
  logic clock, rst, start, busy, done;
  logic [N*N*EW-1:0] mat_a, mat_b;
  logic [N*N*OW-1:0] mat_c;
  int pass_cnt = 0;
  int total_cnt = 0;
  vec_t vecs[NV];
  matrix_mult_engine dut (
    .clock(clock),
    .rst  (rst),
    .start(start),
    .mat_a(mat_a),
    .mat_b(mat_b),
    .busy (busy),
    .done (done),
    .mat_c(mat_c)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic check(input string nm, input logic [N*N*OW-1:0] act, input logic [N*N*OW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [N*N*OW-1:0] model(input logic [N*N*EW-1:0] a, input logic [N*N*EW-1:0] b);
    logic [N*N*OW-1:0] c;
    c = '0;
    for (int r = 0; r < N; r++)
      for (int cc = 0; cc < N; cc++) begin
        int s;
        s = 0;
        for (int q = 0; q < N; q++)
          s += int'(a[((N*N-1)-(r*N+q))*EW +: EW]) * int'(b[((N*N-1)-(q*N+cc))*EW +: EW]);
        c[((N*N-1)-(r*N+cc))*OW +: OW] = s[OW-1:0];
      end
    return c;
  endfunction
  function automatic logic [N*N*EW-1:0] rnd_mat();
    logic [N*N*EW-1:0] x;
    for (int q = 0; q < N * N; q++) x[q*EW +: EW] = EW'($urandom);
    return x;
  endfunction
  task automatic run_op(input logic [N*N*EW-1:0] a, input logic [N*N*EW-1:0] b, output int n);
    @(negedge clock);
    mat_a = a;
    mat_b = b;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
  endtask
  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 300) begin
      @(negedge clock);
      w++;
    end
    check("wait_idle", busy, 0);
  endtask
  initial begin
    int n, e, idle_cnt, idle_bad;
    int dq[$];
    logic [N*N*EW-1:0] a0, b0;
    logic [N*N*OW-1:0] exp;
    rst = 1'b1;
    start = 1'b0;
    mat_a = '0;
    mat_b = '0;
    for (int v = 0; v < NV; v++) begin
      vecs[v].a = '0;
      vecs[v].b = '0;
      vecs[v].c = '0;
    end
    vecs[0].name = "identity";
    for (int r = 0; r < N; r++) vecs[0].a[((N*N-1)-(r*N+r))*EW +: EW] = 1;
    for (int q = 0; q < N * N; q++) begin
      vecs[0].b[((N*N-1)-q)*EW +: EW] = EW'(q);
      vecs[0].c[((N*N-1)-q)*OW +: OW] = OW'(q);
    end
    vecs[1].name = "all_max";
    for (int q = 0; q < N * N; q++) begin
      vecs[1].a[q*EW +: EW] = 63;
      vecs[1].b[q*EW +: EW] = 63;
      vecs[1].c[q*OW +: OW] = 15876;
    end
    vecs[2].name = "row0";
    for (int q = 0; q < N; q++) vecs[2].a[((N*N-1)-q)*EW +: EW] = EW'(q + 1);
    for (int q = 0; q < N * N; q++) vecs[2].b[q*EW +: EW] = 1;
    for (int q = 0; q < N; q++) vecs[2].c[((N*N-1)-q)*OW +: OW] = 10;
    for (int v = 3; v < NV; v++) begin
      vecs[v].name = $sformatf("rand%0d", v);
      vecs[v].a = rnd_mat();
      vecs[v].b = rnd_mat();
      vecs[v].c = model(vecs[v].a, vecs[v].b);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_mat_c", mat_c, '0);
    rst = 1'b0;
    for (int v = 0; v < NV; v++) begin
      run_op(vecs[v].a, vecs[v].b, n);
      check({vecs[v].name, "_done_edge"}, n, NC);
      check({vecs[v].name, "_mat_c"}, mat_c, vecs[v].c);
      if (v == 2) check("row0_msb_entry", mat_c[N*N*OW-1 -: OW], 10);
      @(negedge clock);
      check({vecs[v].name, "_done_pulse"}, {busy, done}, 2'b00);
    end
    @(negedge clock);
    start = 1'b1;
    mat_a = vecs[3].a;
    mat_b = vecs[3].b;
    @(posedge clock);
    idle_cnt = 0;
    idle_bad = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (done) dq.push_back(t);
      if (!busy) begin
        idle_cnt++;
        if (!(dq.size() > 0 && dq[$] == t - 1)) idle_bad++;
      end
      @(posedge clock);
    end
    @(negedge clock);
    start = 1'b0;
    check("held_done_count", dq.size(), 3);
    check("held_done0", dq.size() > 0 ? dq[0] : -1, NC);
    check("held_done1", dq.size() > 1 ? dq[1] : -1, 2 * NC + 2);
    check("held_done2", dq.size() > 2 ? dq[2] : -1, 3 * NC + 4);
    check("held_idle_count", idle_cnt, 3);
    check("held_idle_after_done", idle_bad, 0);
    wait_idle();
    a0 = rnd_mat();
    b0 = rnd_mat();
    exp = model(a0, b0);
    @(negedge clock);
    mat_a = a0;
    mat_b = b0;
    start = 1'b1;
    @(posedge clock);
    e = 0;
    while (1) begin
      @(negedge clock);
      if (done || e >= 200) break;
      if (e == 5) begin
        mat_a = rnd_mat();
        mat_b = rnd_mat();
      end
      start = (e == 10 || e == 40);
      @(posedge clock);
      e++;
    end
    start = 1'b0;
    check("ignore_done_edge", e, NC);
    check("ignore_mat_c", mat_c, exp);
    @(negedge clock);
    check("ignore_not_queued", busy, 0);
    @(negedge clock);
    check("ignore_still_idle", busy, 0);
    check("ignore_mat_c_held", mat_c, exp);
    @(negedge clock);
    mat_a = rnd_mat();
    mat_b = rnd_mat();
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (29) @(posedge clock);
    @(negedge clock);
    rst = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_mat_c", mat_c, '0);
    @(negedge clock);
    check("midrst_idle", busy, 0);
    a0 = rnd_mat();
    b0 = rnd_mat();
    run_op(a0, b0, n);
    check("midrst_fresh_edge", n, NC);
    check("midrst_fresh_mat_c", mat_c, model(a0, b0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
